host_bus_bridge: RTL and testbench

HOST_BUS_BRIDGE -- requirements
Module: host_bus_bridge

---
 rtl/host_bus_bridge_if.sv | 26 ++
 rtl/host_bus_bridge.sv | 139 +++++++++++++
 tb/tb_host_bus_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/host_bus_bridge_if.sv
// Host-side request/response bus of the host bus bridge.
// The bridge takes the slave view; the host (or a bench) takes the master view.
interface host_bus_bridge_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) ();
  logic              t_cs;
  logic              t_rw;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  logic              t_ready;
  logic [DATA_W-1:0] t_rdata;
  logic              t_rvalid;
  logic              t_err;
  logic              int_flag;

  modport slave (
    input  t_cs, t_rw, t_addr, t_wdata,
    output t_ready, t_rdata, t_rvalid, t_err, int_flag
  );

  modport master (
    output t_cs, t_rw, t_addr, t_wdata,
    input  t_ready, t_rdata, t_rvalid, t_err, int_flag
  );
endinterface

// File: rtl/host_bus_bridge.sv
// Bridges host bus transactions onto banked SRAM or a small control register
// block that starts an external core and raises an interrupt when it finishes.
module host_bus_bridge #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32,
  parameter int NBANK   = 2,
  parameter int BANK_AW = 10,
  parameter int RD_LAT  = 3
) (
  input  logic               clk,
  input  logic               reset_b,
  host_bus_bridge_if.slave   host,
  output logic               mem_req,
  output logic               mem_we,
  output logic [NBANK-1:0]   mem_bank,
  output logic [BANK_AW-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               core_start,
  input  logic               core_done
);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic               rw_q;
  logic               is_reg_q;
  logic [1:0]         idx_q;
  logic [2:0]         bank_q;
  logic [BANK_AW-1:0] word_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               err_q;
  logic [3:0]         cnt_q;
  logic               busy_q, int_en_q, int_flag_q;
  logic [DATA_W-1:0]  rdata_q;

  logic               accept;
  logic               err_in;
  logic               mem_ok;
  logic               ctrl_wr;
  logic [DATA_W-1:0]  reg_rdata;
  logic [NBANK-1:0]   bank_oh;
  logic               unused_addr;

  assign accept  = (state_q == IDLE) && host.t_cs;
  // Out-of-range banks and SRAM accesses while the core owns memory are refused.
  assign err_in  = !host.t_addr[ADDR_W-1] &&
                   ((32'(host.t_addr[BANK_AW +: 3]) >= NBANK) || busy_q);
  assign mem_ok  = !is_reg_q && !err_q;
  assign ctrl_wr = (state_q == WR) && is_reg_q && (idx_q == 2'd1);
  assign unused_addr = ^host.t_addr[ADDR_W-2:BANK_AW+3];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host.t_cs) state_d = host.t_rw ? RD_WAIT : WR;
      WR:      state_d = IDLE;
      RD_WAIT: if (cnt_q == 4'(RD_LAT - 1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_rdata = '0;
    case (idx_q)
      2'd0:    reg_rdata[2:0] = {int_en_q, int_flag_q, busy_q};
      2'd1:    reg_rdata[1]   = int_en_q;
      default: reg_rdata      = '0;
    endcase
  end

  always_comb begin
    bank_oh = '0;
    for (int i = 0; i < NBANK; i++) bank_oh[i] = (bank_q == 3'(i));
  end

  assign host.t_ready    = (state_q == IDLE);
  assign host.t_rvalid   = (state_q == RESP);
  assign host.t_err      = err_q && (((state_q == WR) && !rw_q) || (state_q == RESP));
  assign host.t_rdata    = rdata_q;
  assign host.int_flag   = int_flag_q;

  // SRAM strobes exist only in the write cycle or the first read-wait cycle.
  assign mem_req   = mem_ok && ((state_q == WR) || ((state_q == RD_WAIT) && (cnt_q == 4'd0)));
  assign mem_we    = mem_req && (state_q == WR);
  assign mem_bank  = mem_req ? bank_oh : '0;
  assign mem_addr  = mem_req ? word_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign core_start = ctrl_wr && wdata_q[0] && !busy_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rw_q       <= 1'b0;
      is_reg_q   <= 1'b0;
      idx_q      <= '0;
      bank_q     <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      int_en_q   <= 1'b0;
      int_flag_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        rw_q     <= host.t_rw;
        is_reg_q <= host.t_addr[ADDR_W-1];
        idx_q    <= host.t_addr[3:2];
        bank_q   <= host.t_addr[BANK_AW +: 3];
        word_q   <= host.t_addr[BANK_AW-1:0];
        wdata_q  <= host.t_wdata;
        err_q    <= err_in;
        cnt_q    <= '0;
      end else if (state_q == RD_WAIT) begin
        cnt_q <= cnt_q + 4'd1;
      end

      // SRAM data arrives the cycle after the request; register data is sampled alongside.
      if ((state_q == RD_WAIT) && (cnt_q == 4'd1))
        rdata_q <= err_q ? '0 : (is_reg_q ? reg_rdata : mem_rdata);

      if (core_start)                busy_q <= 1'b1;
      else if (busy_q && core_done)  busy_q <= 1'b0;

      if (ctrl_wr) int_en_q <= wdata_q[1];

      if (busy_q && core_done && int_en_q)  int_flag_q <= 1'b1;
      else if (ctrl_wr && wdata_q[2])       int_flag_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_host_bus_bridge.sv
// Directed bench for host_bus_bridge with a small SRAM model behind the memory port.
module tb_host_bus_bridge;

  localparam logic [17:0] CTRL_A   = 18'h20004;
  localparam logic [17:0] STATUS_A = 18'h20000;

  logic        clk;
  logic        reset_b;
  logic        mem_req, mem_we;
  logic [1:0]  mem_bank;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        core_start;
  logic        core_done;

  logic [31:0] sram [0:2047];
  int          mem_req_count;
  int          rvalid_count;
  int          vectors;
  int          miscompares;

  logic        obs_req, obs_we, obs_start, obs_err, obs_after_valid;
  logic [1:0]  obs_bank;
  logic [9:0]  obs_addr;
  logic [31:0] obs_wdata, obs_rdata;
  int          obs_lat, obs_reqs;

  host_bus_bridge_if #(.ADDR_W(18), .DATA_W(32)) host_if ();

  host_bus_bridge #(
    .ADDR_W(18), .DATA_W(32), .NBANK(2), .BANK_AW(10), .RD_LAT(3)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .host       (host_if),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_bank   (mem_bank),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .core_start (core_start),
    .core_done  (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM returns garbage unless it was asked for data on the previous cycle.
  always @(posedge clk) begin
    if (mem_req && mem_we) sram[{mem_bank[1], mem_addr}] <= mem_wdata;
    mem_rdata <= (mem_req && !mem_we) ? sram[{mem_bank[1], mem_addr}] : 32'hDEAD_BEEF;
  end

  initial mem_req_count = 0;
  initial rvalid_count = 0;
  always @(posedge clk) begin
    if (mem_req) mem_req_count++;
    if (host_if.t_rvalid) rvalid_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One host transaction starting from IDLE; observations land in the obs_* variables.
  task automatic applyStimulus(input logic rw, input logic [17:0] addr,
                               input logic [31:0] wdata, input logic done_in_wr);
    int base;
    base = mem_req_count;
    host_if.t_cs    = 1'b1;
    host_if.t_rw    = rw;
    host_if.t_addr  = addr;
    host_if.t_wdata = wdata;
    @(posedge clk); #1;
    host_if.t_cs = 1'b0;
    obs_req   = mem_req;
    obs_we    = mem_we;
    obs_bank  = mem_bank;
    obs_addr  = mem_addr;
    obs_wdata = mem_wdata;
    obs_start = core_start;
    obs_err   = host_if.t_err;
    obs_lat   = 0;
    if (!rw) begin
      if (done_in_wr) core_done = 1'b1;
      @(posedge clk); #1;
      core_done = 1'b0;
    end else begin
      while (!host_if.t_rvalid && obs_lat < 20) begin
        @(posedge clk); #1;
        obs_lat++;
      end
      obs_err   = host_if.t_err;
      obs_rdata = host_if.t_rdata;
      @(posedge clk); #1;
    end
    obs_after_valid = host_if.t_rvalid;
    obs_reqs = mem_req_count - base;
  endtask

  initial begin
    int rv_base;
    int base;
    vectors = 0;
    miscompares = 0;
    reset_b = 1'b0;
    core_done = 1'b0;
    host_if.t_cs = 1'b0;
    host_if.t_rw = 1'b0;
    host_if.t_addr = '0;
    host_if.t_wdata = '0;

    #12;
    checkOutput("rst_ready",  host_if.t_ready, 1);
    checkOutput("rst_rvalid", host_if.t_rvalid, 0);
    checkOutput("rst_err",    host_if.t_err, 0);
    checkOutput("rst_int",    host_if.int_flag, 0);
    checkOutput("rst_rdata",  host_if.t_rdata, 0);
    checkOutput("rst_memreq", {mem_req, mem_we, mem_bank}, 0);
    checkOutput("rst_start",  core_start, 0);
    @(posedge clk); #1;
    reset_b = 1'b1;

    applyStimulus(1'b0, 18'h00403, 32'h0000_0005, 1'b0);
    checkOutput("wr_req",   {obs_req, obs_we}, 2'b11);
    checkOutput("wr_bank",  obs_bank, 2'b10);
    checkOutput("wr_addr",  obs_addr, 10'h003);
    checkOutput("wr_wdata", obs_wdata, 32'h5);
    checkOutput("wr_err",   obs_err, 0);
    checkOutput("wr_reqs",  obs_reqs, 1);

    applyStimulus(1'b1, 18'h00403, 32'h0, 1'b0);
    checkOutput("rd_data",  obs_rdata, 32'h5);
    checkOutput("rd_lat",   obs_lat, 3);
    checkOutput("rd_err",   obs_err, 0);
    checkOutput("rd_reqs",  obs_reqs, 1);
    checkOutput("rd_pulse", obs_after_valid, 0);

    applyStimulus(1'b0, 18'h00803, 32'h1234_5678, 1'b0);
    checkOutput("badwr_reqs", obs_reqs, 0);
    checkOutput("badwr_err",  obs_err, 1);

    applyStimulus(1'b1, 18'h00803, 32'h0, 1'b0);
    checkOutput("badrd_data", obs_rdata, 0);
    checkOutput("badrd_err",  obs_err, 1);
    checkOutput("badrd_lat",  obs_lat, 3);
    checkOutput("badrd_reqs", obs_reqs, 0);

    applyStimulus(1'b0, CTRL_A, 32'h3, 1'b0);
    checkOutput("start_pulse", obs_start, 1);
    checkOutput("start_err",   obs_err, 0);
    checkOutput("start_reqs",  obs_reqs, 0);

    applyStimulus(1'b1, STATUS_A, 32'h0, 1'b0);
    checkOutput("status_busy", obs_rdata, 32'h5);
    checkOutput("status_lat",  obs_lat, 3);

    applyStimulus(1'b1, 18'h00403, 32'h0, 1'b0);
    checkOutput("busyrd_err",  obs_err, 1);
    checkOutput("busyrd_data", obs_rdata, 0);
    checkOutput("busyrd_reqs", obs_reqs, 0);

    applyStimulus(1'b0, CTRL_A, 32'h3, 1'b0);
    checkOutput("restart_pulse", obs_start, 0);
    checkOutput("restart_err",   obs_err, 0);

    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    checkOutput("done_int", host_if.int_flag, 1);

    applyStimulus(1'b1, STATUS_A, 32'h0, 1'b0);
    checkOutput("status_done", obs_rdata, 32'h6);
    applyStimulus(1'b1, CTRL_A, 32'h0, 1'b0);
    checkOutput("ctrl_read", obs_rdata, 32'h2);

    applyStimulus(1'b1, 18'h20008, 32'h0, 1'b0);
    checkOutput("reg2_data", obs_rdata, 0);
    checkOutput("reg2_err",  obs_err, 0);
    applyStimulus(1'b0, 18'h2000C, 32'hFFFF_FFFF, 1'b0);
    checkOutput("reg3_err",  obs_err, 0);
    checkOutput("reg3_side", {obs_start, 1'(obs_reqs)}, 0);

    applyStimulus(1'b0, CTRL_A, 32'h4, 1'b0);
    checkOutput("clr_int", host_if.int_flag, 0);
    applyStimulus(1'b0, CTRL_A, 32'h3, 1'b0);
    checkOutput("start2_pulse", obs_start, 1);
    applyStimulus(1'b0, CTRL_A, 32'h4, 1'b1);
    checkOutput("set_beats_clr", host_if.int_flag, 1);
    applyStimulus(1'b1, STATUS_A, 32'h0, 1'b0);
    checkOutput("status_after", obs_rdata, 32'h2);
    applyStimulus(1'b0, CTRL_A, 32'h4, 1'b0);
    checkOutput("clr_int2", host_if.int_flag, 0);

    applyStimulus(1'b0, 18'h00005, 32'hA5A5_0001, 1'b0);
    applyStimulus(1'b0, CTRL_A, 32'h2, 1'b0);
    rv_base = rvalid_count;
    host_if.t_cs = 1'b1;
    host_if.t_rw = 1'b1;
    host_if.t_addr = 18'h00005;
    @(posedge clk); #1;
    host_if.t_cs = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b0;
    #1;
    checkOutput("arst_ready",  host_if.t_ready, 1);
    checkOutput("arst_outs",   {host_if.t_rvalid, host_if.t_err, host_if.int_flag, mem_req, core_start}, 0);
    checkOutput("arst_rdata",  host_if.t_rdata, 0);
    checkOutput("arst_mem",    {mem_bank, mem_addr, mem_wdata}, 0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("arst_norsp", rvalid_count - rv_base, 0);
    reset_b = 1'b1;
    applyStimulus(1'b1, 18'h00005, 32'h0, 1'b0);
    checkOutput("post_rd_data", obs_rdata, 32'hA5A5_0001);
    checkOutput("post_rd_lat",  obs_lat, 3);
    applyStimulus(1'b1, STATUS_A, 32'h0, 1'b0);
    checkOutput("post_status", obs_rdata, 0);

    base = mem_req_count;
    host_if.t_cs = 1'b1;
    host_if.t_rw = 1'b0;
    host_if.t_addr = 18'h00010;
    host_if.t_wdata = 32'h0000_0007;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("b2b_req%0d", k), mem_req, (k % 2 == 0) ? 1 : 0);
    end
    host_if.t_cs = 1'b0;
    checkOutput("b2b_count", mem_req_count - base, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
